// File: rtl/prod_acc_pkg.sv
// Shared types and defaults for the product accumulator stage.
// Imported by the accumulator top and its adder.
package prod_acc_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    localparam int PROD_W_DEF = 8;
    localparam int ACC_W_DEF  = 16;
    localparam int COUNT_DEF  = 4;

endpackage

// File: rtl/acc_adder.sv
// Ripple-carry accumulator adder; operand b is zero-extended to ACC_W.
// Carry out of the top bit feeds the sticky overflow flag.
module acc_adder
    import prod_acc_pkg::*;
#(
    parameter int ACC_W  = ACC_W_DEF,
    parameter int PROD_W = PROD_W_DEF
) (
    input  logic [ACC_W-1:0]  a,
    input  logic [PROD_W-1:0] b,
    output logic [ACC_W-1:0]  sum,
    output logic              carry
);

    logic [ACC_W-1:0] b_ext;
    logic [ACC_W:0]   c;

    assign b_ext = ACC_W'(b);
    assign c[0]  = 1'b0;

    for (genvar i = 0; i < ACC_W; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b_ext[i] ^ c[i];
        assign c[i+1]   = (a[i] & b_ext[i]) | (c[i] & (a[i] ^ b_ext[i]));
    end

    assign carry = c[ACC_W];

endmodule

// File: rtl/product_accumulator.sv
// Sums COUNT consecutive multiplier products and presents the total
// on a valid/ready port; one result at a time, held until taken.
module product_accumulator
    import prod_acc_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int COUNT  = COUNT_DEF,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_p,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf,
    output logic              busy
);

    state_e           state;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic             carry;
    logic             accept;
    logic             last;

    acc_adder #(
        .ACC_W  (ACC_W),
        .PROD_W (PROD_W)
    ) u_adder (
        .a     (acc),
        .b     (in_p),
        .sum   (sum),
        .carry (carry)
    );

    // in_ready is a pure state decode: no path from in_valid
    assign in_ready = (state == ACCUM);
    assign accept   = in_valid & in_ready;
    assign last     = (cnt == CNT_W'(COUNT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
        end else if (clr) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            unique case (1'b1)
                (state == ACCUM): begin
                    if (accept) begin
                        if (last) begin
                            out_sum   <= sum;
                            out_ovf   <= ovf | carry;
                            out_valid <= 1'b1;
                            acc       <= '0;
                            cnt       <= '0;
                            ovf       <= 1'b0;
                            busy      <= 1'b0;
                            state     <= HOLD;
                        end else begin
                            acc  <= sum;
                            ovf  <= ovf | carry;
                            cnt  <= cnt + CNT_W'(1);
                            busy <= 1'b1;
                        end
                    end
                end
                (state == HOLD): begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench: spec-level model checked every cycle plus literal results.
module tb_product_accumulator;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_p;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_ovf;
    logic        busy;

    logic        s_in_valid;
    logic        s_in_ready;
    logic [7:0]  s_in_p;
    logic        s_out_valid;
    logic [7:0]  s_out_sum;
    logic        s_out_ovf;
    logic        s_busy;

    int total;
    int bad;
    bit started;

    product_accumulator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_p      (in_p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    product_accumulator #(
        .PROD_W (8),
        .ACC_W  (8),
        .COUNT  (2),
        .CNT_W  (4)
    ) dut_s (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (1'b0),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in_p      (s_in_p),
        .out_valid (s_out_valid),
        .out_ready (1'b1),
        .out_sum   (s_out_sum),
        .out_ovf   (s_out_ovf),
        .busy      (s_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a result is the plain sum of COUNT accepted products.
    bit m_hold;
    int m_n;
    int m_total;
    int m_sum;
    int m_ovf;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_hold  = 0;
            m_n     = 0;
            m_total = 0;
            m_sum   = 0;
            m_ovf   = 0;
        end else if (clr) begin
            m_hold  = 0;
            m_n     = 0;
            m_total = 0;
        end else if (m_hold) begin
            if (out_ready) m_hold = 0;
        end else if (in_valid) begin
            m_total += int'(in_p);
            m_n++;
            if (m_n == 4) begin
                m_sum   = m_total % 65536;
                m_ovf   = (m_total > 65535) ? 1 : 0;
                m_hold  = 1;
                m_n     = 0;
                m_total = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("m_in_ready", int'(in_ready), m_hold ? 0 : 1);
            chk("m_out_valid", int'(out_valid), m_hold ? 1 : 0);
            chk("m_busy", int'(busy), (m_n > 0) ? 1 : 0);
            chk("m_out_sum", int'(out_sum), m_sum);
            chk("m_out_ovf", int'(out_ovf), m_ovf);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] p);
        in_valid = 1'b1;
        in_p     = p;
        for (int k = 0; k < 20 && !in_ready; k++) step();
        if (!in_ready) chk("send_timeout", 0, 1);
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        started    = 0;
        rst_n      = 1'b0;
        clr        = 1'b0;
        in_valid   = 1'b0;
        in_p       = '0;
        out_ready  = 1'b1;
        s_in_valid = 1'b0;
        s_in_p     = '0;
        step();
        step();
        rst_n   = 1'b1;
        started = 1;
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_sum", int'(out_sum), 0);
        chk("rst_busy", int'(busy), 0);

        // basic back-to-back group
        send(8'd15); send(8'd30); send(8'd45); send(8'd60);
        chk("basic_valid", int'(out_valid), 1);
        chk("basic_sum", int'(out_sum), 150);
        chk("basic_ovf", int'(out_ovf), 0);
        step();
        chk("basic_ready_after", int'(in_ready), 1);
        chk("basic_valid_after", int'(out_valid), 0);

        // backpressure, with a product offered while holding
        out_ready = 1'b0;
        send(8'd225); send(8'd225); send(8'd225); send(8'd225);
        in_valid = 1'b1;
        in_p     = 8'd7;
        for (int i = 0; i < 5; i++) begin
            chk("bp_sum", int'(out_sum), 900);
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_valid", int'(out_valid), 1);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_release", int'(out_valid), 0);

        // gapped input
        for (int i = 1; i <= 4; i++) begin
            send(8'(i));
            if (i < 4) begin
                chk("gap_busy", int'(busy), 1);
                step();
                chk("gap_busy_idle", int'(busy), 1);
                step();
            end
        end
        chk("gap_sum", int'(out_sum), 10);
        chk("gap_busy_done", int'(busy), 0);
        step();

        // overflow on the narrow instance
        s_in_valid = 1'b1;
        s_in_p     = 8'd200;
        step();
        s_in_p     = 8'd100;
        step();
        s_in_valid = 1'b0;
        chk("ovf_valid", int'(s_out_valid), 1);
        chk("ovf_sum", int'(s_out_sum), 44);
        chk("ovf_flag", int'(s_out_ovf), 1);
        step();
        s_in_valid = 1'b1;
        s_in_p     = 8'd1;
        step();
        step();
        s_in_valid = 1'b0;
        chk("ovf2_sum", int'(s_out_sum), 2);
        chk("ovf2_flag", int'(s_out_ovf), 0);
        step();

        // clr mid-group drops offered product
        send(8'd50); send(8'd60);
        in_valid = 1'b1;
        in_p     = 8'd70;
        clr      = 1'b1;
        step();
        clr      = 1'b0;
        in_valid = 1'b0;
        chk("clr_busy", int'(busy), 0);
        chk("clr_in_ready", int'(in_ready), 1);
        out_ready = 1'b0;
        send(8'd1); send(8'd1); send(8'd1); send(8'd1);
        chk("clr_sum", int'(out_sum), 4);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_hold_valid", int'(out_valid), 0);
        out_ready = 1'b1;

        // reset mid-group and during hold
        send(8'd9); send(8'd9);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rst2_busy", int'(busy), 0);
        chk("rst2_sum", int'(out_sum), 0);
        out_ready = 1'b0;
        send(8'd5); send(8'd5); send(8'd5); send(8'd5);
        chk("rst3_pre_valid", int'(out_valid), 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rst3_valid", int'(out_valid), 0);
        chk("rst3_ovf", int'(out_ovf), 0);
        chk("rst3_sum", int'(out_sum), 0);
        out_ready = 1'b1;
        send(8'd10); send(8'd20); send(8'd30); send(8'd40);
        chk("post_rst_sum", int'(out_sum), 100);
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
